// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module   : logic_gate_unit
// Brief    : Registered WIDTH-bit bitwise logic unit with valid/ready
//            handshake, accumulator feedback, result flags and a txn counter.
// Revision : 1.0 - initial release
// ============================================================================
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_NOT  = 3'd2;
    localparam logic [2:0] c_OP_NAND = 3'd3;
    localparam logic [2:0] c_OP_NOR  = 3'd4;
    localparam logic [2:0] c_OP_XOR  = 3'd5;
    localparam logic [2:0] c_OP_XNOR = 3'd6;

    logic             r_valid;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_res;

    assign in_ready = !rst && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // A same-cycle clear makes the accumulator read as zero for this operation
    assign w_opa = acc_en ? (acc_clr ? '0 : r_acc) : a;

    always_comb begin
        w_res = '0;
        case (op)
            c_OP_AND:  w_res = w_opa & b;
            c_OP_OR:   w_res = w_opa | b;
            c_OP_NOT:  w_res = ~w_opa;
            c_OP_NAND: w_res = ~(w_opa & b);
            c_OP_NOR:  w_res = ~(w_opa | b);
            c_OP_XOR:  w_res = w_opa ^ b;
            c_OP_XNOR: w_res = ~(w_opa ^ b);
            default:   w_res = w_opa & ~b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_y     <= w_res;
            r_acc   <= w_res;
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    // Flags derive from the registered result so they always track y
    assign out_valid = r_valid;
    assign y         = r_y;
    assign zero      = ~|r_y;
    assign ones      = &r_y;
    assign parity    = ^r_y;
    assign txn_count = r_cnt;

endmodule
`default_nettype wire

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Parametrised, registered successor of the two-input single-bit logic-gate block.
- Applies one of eight bitwise logic ops to WIDTH-bit operands and returns a registered result with status flags.
- Valid/ready handshake on input and output; optional accumulator mode feeds the previous result back as operand A.
- Sits between a stimulus/command source and any consumer of logic results; also serves as the unit-level regression target for the gate primitives.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1)
- CNT_W, 16, width of accepted-transaction counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand/op presented
- in_ready  output  1  unit can accept this cycle
- a  input  WIDTH  operand A (ignored when acc_en=1)
- b  input  WIDTH  operand B
- op  input  3  opcode: 0 AND, 1 OR, 2 NOT(A), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 ANDN (A & ~B)
- acc_en  input  1  use accumulator in place of A
- acc_clr  input  1  clear accumulator
- out_valid  output  1  result held
- out_ready  input  1  consumer accepts result
- y  output  WIDTH  result
- zero  output  1  y == 0
- ones  output  1  y == all ones
- parity  output  1  XOR-reduction of y
- txn_count  output  CNT_W  number of accepted inputs since reset

Behaviour:
- Reset (rst=1 at clk edge), effective the following cycle:
  - out_valid=0, y=0, zero=1, ones=0, parity=0, txn_count=0, accumulator=0.
  - Any held result is discarded; rst has priority over all other inputs.
- in_ready = !out_valid || out_ready (combinational). in_ready is 0 while rst=1.
- Accept = in_valid && in_ready.
- On accept:
  - Compute on operand pair (A', b), where A' = acc_en ? accumulator : a.
  - If acc_clr=1 in the same cycle, the accumulator reads as 0 for A'.
  - y, zero, ones and parity register the result; out_valid=1 next cycle.
  - The accumulator is loaded with the result.
  - txn_count increments by 1 and wraps modulo 2^CNT_W.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 result/cycle when out_ready is held high; back-to-back accepts are allowed.
- Output hold: while out_valid=1 and out_ready=0, y and flags are stable, in_ready=0, and no accept occurs.
- Simultaneous out_ready=1 and accept: the old result retires and the new result is loaded in the same edge, so out_valid stays 1.
- out_ready=1 with no accept: out_valid drops to 0; y and flags keep their last value.
- acc_clr without accept: accumulator <= 0; y, out_valid and txn_count are unchanged.
- acc_en, acc_clr and op are sampled only on accept (except acc_clr, which also acts alone as above).
- NOT ignores b. All ops are purely bitwise; there is no carry and no cross-bit dependency other than the flags.
- Flags are computed from the registered result and always describe the current y.
- WIDTH=1 is legal: ones==!zero and parity==y.

Test Plan:
- Truth-table sweep, WIDTH=8: a=8'hF0, b=8'hCC, op 0..7, out_ready=1 -> y = C0, FC, 0F, 3F, 03, 3C, C3, 30 on consecutive cycles; txn_count=8.
- Flags: a=8'hFF, b=8'hFF, op=0 -> y=FF, ones=1, zero=0, parity=0. Then op=5 -> y=00, zero=1, parity=0. Then a=8'h01, b=8'h00, op=1 -> parity=1.
- Backpressure: accept a=8'hAA, b=8'h0F, op=0; hold out_ready=0 for 3 cycles -> y=0A stable, in_ready=0, a second in_valid is not accepted. Release -> second op accepted in the same cycle.
- Accumulate chain: acc_clr=1 with acc_en=1, b=8'h01, op=1; then acc_en=1, b=8'h02, op=1; then acc_en=1, b=8'h04, op=5 -> y = 01, 03, 07.
- Reset mid-operation: out_valid=1 with out_ready=0, assert rst one cycle -> out_valid=0, y=00, zero=1, txn_count=0. Accumulator is 0, checked with acc_en=1, b=8'h00, op=1 -> y=00.
- Counter wrap, CNT_W=2: 5 accepts -> txn_count sequence 1, 2, 3, 0, 1.
